// File: rtl/midi_preset_bank.sv
// midi_preset_bank: N-slot MIDI preset store, loaded from SPI flash after reset, with learn/recall.
// Optional feature macro: CHANNEL_OVERRIDE_EN (adds channel_i, replaces the recalled status low nibble).
module midi_preset_bank #(
  parameter int unsigned BUTTONS_CNT = 4,
  parameter logic [23:0] BASE_ADDR   = 24'h1ffd80,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned ACK_TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             btn_index,
  input  logic                   btn_valid,
  input  logic                   save_mode,
  input  logic                   midi_in_valid,
  input  logic [7:0]             status_in,
  input  logic [7:0]             data1_in,
  input  logic [7:0]             data2_in,
  input  logic [1:0]             bytes_cnt_in,
`ifdef CHANNEL_OVERRIDE_EN
  input  logic [3:0]             channel_i,
`endif
  output logic [23:0]            spi_adr_o,
  output logic                   spi_we_o,
  output logic                   spi_stb_o,
  input  logic [31:0]            spi_dat_i,
  input  logic                   spi_ack_i,
  input  logic                   spi_rty_i,
  input  logic                   cmd_busy_i,
  output logic [7:0]             status,
  output logic [7:0]             data1,
  output logic [7:0]             data2,
  output logic [7:0]             cmd_bits_cnt,
  output logic                   cmd_trigger_out,
  output logic [BUTTONS_CNT-1:0] slot_valid,
  output logic                   load_done,
  output logic                   load_fail
);

  localparam int unsigned TW        = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned RW        = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [3:0]    SLOT_LAST = 4'(BUTTONS_CNT - 1);

  typedef enum logic [1:0] {S_LOAD_REQ, S_LOAD_WAIT, S_LOAD_GAP, S_IDLE} state_t;

  state_t                 r_state;
  logic [3:0]             r_slot;
  logic [RW-1:0]          r_retry;
  logic [TW-1:0]          r_tmo;
  logic                   r_advance;
  logic [31:0]            r_mem [BUTTONS_CNT];
  logic                   r_pend;
  logic [31:0]            r_pend_word;
  logic                   r_q_vld;
  logic [BUTTONS_CNT-1:0] r_q_1h;

  logic [BUTTONS_CNT-1:0] w_btn_1h;
  logic [31:0]            w_btn_word;
  logic [31:0]            w_q_word;
  logic [31:0]            w_in_word;
  logic [31:0]            w_learn_word;
  logic [31:0]            w_out_word;
  logic [7:0]             w_out_status;
  logic                   w_idle;
  logic                   w_btn_in;
  logic                   w_learn;
  logic                   w_recall;
  logic                   w_q_issue;
  logic                   w_now;
  logic                   w_word_ok;
  logic                   w_tmo;
  logic [RW-1:0]          w_retry_inc;
  logic [23:0]            w_load_adr;

  assign spi_we_o = 1'b0;

  // Button index decoded one-hot so slot lookups never index past BUTTONS_CNT.
  always_comb begin
    w_btn_1h   = '0;
    w_btn_word = '0;
    w_q_word   = '0;
    for (int unsigned i = 0; i < BUTTONS_CNT; i++) begin
      if (btn_index == 4'(i + 1)) begin
        w_btn_1h[i] = 1'b1;
        w_btn_word  = r_mem[i];
      end
      if (r_q_1h[i]) w_q_word = r_mem[i];
    end
  end

  assign w_in_word    = {status_in, data1_in, data2_in, 8'(bytes_cnt_in) * 8'd10};
  assign w_learn_word = midi_in_valid ? w_in_word : r_pend_word;
  assign w_idle       = (r_state == S_IDLE);
  assign w_btn_in     = |w_btn_1h;
  assign w_learn      = w_idle && btn_valid && save_mode && w_btn_in && (midi_in_valid || r_pend);
  assign w_recall     = w_idle && btn_valid && !save_mode && |(w_btn_1h & slot_valid);
  assign w_q_issue    = w_idle && r_q_vld && !cmd_busy_i;
  assign w_now        = w_recall && !cmd_busy_i && !w_q_issue;
  assign w_out_word   = w_q_issue ? w_q_word : w_btn_word;
`ifdef CHANNEL_OVERRIDE_EN
  assign w_out_status = {w_out_word[31:28], channel_i};
`else
  assign w_out_status = w_out_word[31:24];
`endif
  assign w_word_ok    = spi_dat_i[31] &&
                        (spi_dat_i[7:0] == 8'd10 || spi_dat_i[7:0] == 8'd20 || spi_dat_i[7:0] == 8'd30);
  assign w_tmo        = (r_tmo == TMO_LAST);
  assign w_retry_inc  = r_retry + RW'(1);
  assign w_load_adr   = BASE_ADDR + {18'd0, r_slot, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_LOAD_REQ;
      r_slot          <= '0;
      r_retry         <= '0;
      r_tmo           <= '0;
      r_advance       <= 1'b0;
      r_pend          <= 1'b0;
      r_pend_word     <= '0;
      r_q_vld         <= 1'b0;
      r_q_1h          <= '0;
      spi_adr_o       <= '0;
      spi_stb_o       <= 1'b0;
      status          <= '0;
      data1           <= '0;
      data2           <= '0;
      cmd_bits_cnt    <= '0;
      cmd_trigger_out <= 1'b0;
      slot_valid      <= '0;
      load_done       <= 1'b0;
      load_fail       <= 1'b0;
    end else begin
      cmd_trigger_out <= 1'b0;
      if (w_learn) begin
        r_pend <= 1'b0;
      end else if (midi_in_valid) begin
        r_pend      <= 1'b1;
        r_pend_word <= w_in_word;
      end

      case (r_state)
        S_LOAD_REQ: begin
          spi_stb_o <= 1'b1;
          spi_adr_o <= w_load_adr;
          r_tmo     <= '0;
          r_state   <= S_LOAD_WAIT;
        end
        S_LOAD_WAIT: begin
          if (spi_ack_i) begin
            spi_stb_o <= 1'b0;
            for (int unsigned i = 0; i < BUTTONS_CNT; i++) begin
              if (r_slot == 4'(i)) begin
                r_mem[i]      <= spi_dat_i;
                slot_valid[i] <= w_word_ok;
              end
            end
            r_advance <= 1'b1;
            r_state   <= S_LOAD_GAP;
          end else if (spi_rty_i || w_tmo) begin
            spi_stb_o <= 1'b0;
            if (w_retry_inc <= RETRY_MAX) begin
              r_retry   <= w_retry_inc;
              r_advance <= 1'b0;
            end else begin
              load_fail <= 1'b1;
              r_advance <= 1'b1;
            end
            r_state <= S_LOAD_GAP;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_LOAD_GAP: begin
          if (!spi_ack_i && !spi_rty_i) begin
            if (r_advance) begin
              r_retry <= '0;
              if (r_slot == SLOT_LAST) begin
                load_done <= 1'b1;
                r_state   <= S_IDLE;
              end else begin
                r_slot  <= r_slot + 4'd1;
                r_state <= S_LOAD_REQ;
              end
            end else begin
              r_state <= S_LOAD_REQ;
            end
          end
        end
        S_IDLE: begin
          if (w_learn) begin
            for (int unsigned i = 0; i < BUTTONS_CNT; i++) begin
              if (w_btn_1h[i]) begin
                r_mem[i]      <= w_learn_word;
                slot_valid[i] <= 1'b1;
              end
            end
          end
          if (w_q_issue || w_now) begin
            status          <= w_out_status;
            data1           <= w_out_word[23:16];
            data2           <= w_out_word[15:8];
            cmd_bits_cnt    <= w_out_word[7:0];
            cmd_trigger_out <= 1'b1;
          end
          // A press that cannot go out this cycle (busy, or queue draining) parks in the queue.
          if (w_recall && (cmd_busy_i || w_q_issue)) begin
            r_q_vld <= 1'b1;
            r_q_1h  <= w_btn_1h;
          end else if (w_q_issue) begin
            r_q_vld <= 1'b0;
          end
        end
        default: r_state <= S_LOAD_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_preset_bank.sv
// Scoreboard bench for midi_preset_bank: flash responder, reference model, request/trigger monitors.
`timescale 1ns/1ps
module tb_midi_preset_bank;
  localparam int unsigned N    = 4;
  localparam logic [23:0] BASE = 24'h1ffd80;
  localparam int unsigned MAXR = 3;
  localparam int unsigned TMO  = 64;
  localparam int unsigned LOAD_LIMIT = 4 * (MAXR + 1) * (TMO + 8) + 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btn_index = '0;
  logic        btn_valid = 1'b0, save_mode = 1'b0, midi_in_valid = 1'b0;
  logic [7:0]  status_in = '0, data1_in = '0, data2_in = '0;
  logic [1:0]  bytes_cnt_in = '0;
  logic [23:0] spi_adr_o;
  logic        spi_we_o, spi_stb_o;
  logic [31:0] spi_dat_i = '0;
  logic        spi_ack_i = 1'b0, spi_rty_i = 1'b0, cmd_busy_i = 1'b0;
  logic [7:0]  status, data1, data2, cmd_bits_cnt;
  logic        cmd_trigger_out, load_done, load_fail;
  logic [N-1:0] slot_valid;
`ifdef CHANNEL_OVERRIDE_EN
  logic [3:0]  channel_i = '0;
`endif

  always #5 clk = ~clk;

  midi_preset_bank #(.BUTTONS_CNT(N), .BASE_ADDR(BASE), .MAX_RETRY(MAXR), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .btn_index(btn_index), .btn_valid(btn_valid), .save_mode(save_mode),
    .midi_in_valid(midi_in_valid), .status_in(status_in), .data1_in(data1_in), .data2_in(data2_in),
    .bytes_cnt_in(bytes_cnt_in),
`ifdef CHANNEL_OVERRIDE_EN
    .channel_i(channel_i),
`endif
    .spi_adr_o(spi_adr_o), .spi_we_o(spi_we_o), .spi_stb_o(spi_stb_o), .spi_dat_i(spi_dat_i),
    .spi_ack_i(spi_ack_i), .spi_rty_i(spi_rty_i), .cmd_busy_i(cmd_busy_i),
    .status(status), .data1(data1), .data2(data2), .cmd_bits_cnt(cmd_bits_cnt),
    .cmd_trigger_out(cmd_trigger_out), .slot_valid(slot_valid), .load_done(load_done),
    .load_fail(load_fail)
  );

  int n_chk = 0, n_pass = 0;
  int n_req = 0, n_trig = 0, cur_len = 0, len_min = 0, len_max = 0;
  logic [23:0] exp_adr [$];
  logic [31:0] exp_trig [$];

  logic [31:0] fl_word [N];
  int          fl_rty  [N];
  int          fl_left [N];
  bit          fl_never = 1'b0;

  logic [31:0] m_mem [N];
  bit          m_vld [N];
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_word = '0;
  bit          m_qv = 1'b0;
  int          m_qidx = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_unexpected(input string nm, input logic [63:0] act);
    n_chk++;
    $display("FAIL %s: got %0h expected nothing", nm, act);
  endtask

  function automatic bit word_ok(input logic [31:0] w);
    return w[31] && (w[7:0] == 8'd10 || w[7:0] == 8'd20 || w[7:0] == 8'd30);
  endfunction

  function automatic logic [31:0] trig_of(input logic [31:0] w);
`ifdef CHANNEL_OVERRIDE_EN
    return {w[31:28], channel_i, w[23:0]};
`else
    return w;
`endif
  endfunction

  function automatic logic [N-1:0] mvec();
    logic [N-1:0] v;
    for (int s = 0; s < N; s++) v[s] = m_vld[s];
    return v;
  endfunction

  // Flash responder: answers each request 5 cycles after stb rises; drops everything when stb falls.
  initial begin
    int fcnt, s;
    fcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!spi_stb_o) begin
        spi_ack_i = 1'b0;
        spi_rty_i = 1'b0;
        fcnt = 0;
      end else if (!spi_ack_i && !spi_rty_i) begin
        fcnt++;
        if (fcnt == 5) begin
          s = int'((spi_adr_o - BASE) >> 2);
          if (s >= 0 && s < N) begin
            if (fl_left[s] > 0) begin
              spi_rty_i = 1'b1;
              fl_left[s]--;
            end else if (!fl_never) begin
              spi_ack_i = 1'b1;
              spi_dat_i = fl_word[s];
            end
          end
        end
      end
    end
  end

  // Monitor: flash requests and trigger pulses checked against the expectation queues.
  logic prev_stb = 1'b0;
  always @(negedge clk) begin
    if (spi_stb_o && !prev_stb) begin
      n_req++;
      if (exp_adr.size() == 0) chk_unexpected("unexpected_request", spi_adr_o);
      else chk("request_adr", spi_adr_o, exp_adr.pop_front());
    end
    if (spi_stb_o) cur_len++;
    else if (cur_len > 0) begin
      if (cur_len < len_min) len_min = cur_len;
      if (cur_len > len_max) len_max = cur_len;
      cur_len = 0;
    end
    prev_stb = spi_stb_o;
    if (cmd_trigger_out) begin
      n_trig++;
      if (exp_trig.size() == 0) chk_unexpected("unexpected_trigger", {status, data1, data2, cmd_bits_cnt});
      else chk("trigger_msg", {status, data1, data2, cmd_bits_cnt}, exp_trig.pop_front());
    end
  end

  task automatic do_load();
    int nreq;
    bit ok, efail;
    efail = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    btn_valid = 1'b0;
    midi_in_valid = 1'b0;
    for (int s = 0; s < N; s++) fl_left[s] = fl_rty[s];
    @(negedge clk);
    chk("rst_outputs", {status, data1, data2, cmd_bits_cnt, cmd_trigger_out, load_done, load_fail, spi_stb_o}, '0);
    chk("rst_slot_valid", slot_valid, '0);
    m_pend = 1'b0;
    m_qv = 1'b0;
    exp_adr.delete();
    for (int s = 0; s < N; s++) begin
      ok = !fl_never && fl_rty[s] <= MAXR;
      nreq = ok ? fl_rty[s] + 1 : MAXR + 1;
      repeat (nreq) exp_adr.push_back(BASE + 24'(4 * s));
      m_vld[s] = ok && word_ok(fl_word[s]);
      if (ok) m_mem[s] = fl_word[s];
      if (!ok) efail = 1'b1;
    end
    n_req = 0;
    len_min = 1000000;
    len_max = 0;
    rst = 1'b0;
    for (int c = 0; c < LOAD_LIMIT; c++) begin
      @(negedge clk);
      if (load_done) break;
      // Presses during the load must be ignored; the midi capture still lands in pending.
      btn_valid = 1'b0;
      midi_in_valid = 1'b0;
      if (c == 10) begin btn_index = 4'd1; save_mode = 1'b0; btn_valid = 1'b1; end
      if (c == 15) begin
        {status_in, data1_in, data2_in, bytes_cnt_in} = {8'h91, 8'h40, 8'h33, 2'd3};
        midi_in_valid = 1'b1;
        m_pend = 1'b1;
        m_pend_word = {8'h91, 8'h40, 8'h33, 8'd30};
      end
      if (c == 20) begin btn_index = 4'd2; save_mode = 1'b1; btn_valid = 1'b1; end
    end
    btn_valid = 1'b0;
    midi_in_valid = 1'b0;
    chk("load_done", load_done, 1'b1);
    chk("slot_valid_after_load", slot_valid, mvec());
    chk("load_fail", load_fail, efail);
    chk("request_count", n_req, exp_adr.size() == 0 ? n_req : -1);
    chk("requests_outstanding", exp_adr.size(), 0);
  endtask

  task automatic midi(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2, input logic [1:0] b);
    @(negedge clk);
    {status_in, data1_in, data2_in, bytes_cnt_in} = {st, d1, d2, b};
    midi_in_valid = 1'b1;
    m_pend = 1'b1;
    m_pend_word = {st, d1, d2, 8'(b) * 8'd10};
    @(negedge clk);
    midi_in_valid = 1'b0;
  endtask

  task automatic press(input int idx, input bit save, input bit with_midi, input logic [31:0] mraw);
    logic [31:0] nw;
    bit in_range, have;
    @(negedge clk);
    btn_index = 4'(idx);
    save_mode = save;
    btn_valid = 1'b1;
    nw = {mraw[31:8], 8'(mraw[1:0]) * 8'd10};
    if (with_midi) begin
      {status_in, data1_in, data2_in, bytes_cnt_in} = {mraw[31:8], mraw[1:0]};
      midi_in_valid = 1'b1;
    end
    in_range = idx >= 1 && idx <= N;
    if (save) begin
      have = with_midi || m_pend;
      if (!with_midi) nw = m_pend_word;
      if (in_range && have) begin
        m_mem[idx-1] = nw;
        m_vld[idx-1] = 1'b1;
        m_pend = 1'b0;
      end else if (with_midi) begin
        m_pend = 1'b1;
        m_pend_word = nw;
      end
    end else begin
      if (with_midi) begin m_pend = 1'b1; m_pend_word = nw; end
      if (in_range && m_vld[idx-1]) begin
        if (cmd_busy_i) begin m_qv = 1'b1; m_qidx = idx; end
        else exp_trig.push_back(trig_of(m_mem[idx-1]));
      end
    end
    @(negedge clk);
    btn_valid = 1'b0;
    midi_in_valid = 1'b0;
  endtask

  task automatic release_busy();
    @(negedge clk);
    if (m_qv) exp_trig.push_back(trig_of(m_mem[m_qidx-1]));
    m_qv = 1'b0;
    cmd_busy_i = 1'b0;
  endtask

  task automatic run_ops(input int n);
    for (int k = 0; k < n; k++) begin
`ifdef CHANNEL_OVERRIDE_EN
      channel_i = 4'($urandom);
`endif
      if ($urandom_range(0, 9) < 3)
        midi(8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom_range(1, 3)));
      else
        press($urandom_range(0, 6), 1'($urandom), $urandom_range(0, 3) == 0,
              {24'($urandom), 6'd0, 2'($urandom_range(1, 3))});
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("slot_valid_op", slot_valid, mvec());
    end
    repeat (3) @(negedge clk);
    chk("triggers_drained", exp_trig.size(), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    for (int s = 0; s < N; s++) begin fl_word[s] = 32'hB02E7F1E; fl_rty[s] = 0; end
    repeat (3) @(negedge clk);

    // Clean load.
    do_load();

    // Learn C0,42 (2 bytes) into slot 3, recall it.
`ifdef CHANNEL_OVERRIDE_EN
    channel_i = 4'h0;
`endif
    midi(8'hC0, 8'h42, 8'h11, 2'd2);
    press(3, 1'b1, 1'b0, '0);
    press(3, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("learn_status", status, 8'hC0);
    chk("learn_data1", data1, 8'h42);
    chk("learn_bits", cmd_bits_cnt, 8'd20);

    // Channel override on a loaded B0 slot.
`ifdef CHANNEL_OVERRIDE_EN
    channel_i = 4'h5;
`endif
    press(1, 1'b0, 1'b0, '0);
    @(negedge clk);
`ifdef CHANNEL_OVERRIDE_EN
    chk("channel_status", status, 8'hB5);
`else
    chk("channel_status", status, 8'hB0);
`endif

    // Learn a distinct message into slot 4 with the strobe in the same cycle.
    press(4, 1'b1, 1'b1, {8'h90, 8'h3C, 8'h64, 8'd3});

    // Busy: two presses, one trigger carrying the newer (slot 4).
    cmd_busy_i = 1'b1;
    saved = n_trig;
    press(1, 1'b0, 1'b0, '0);
    press(4, 1'b0, 1'b0, '0);
    repeat (4) @(negedge clk);
    chk("busy_no_trigger", n_trig, saved);
    release_busy();
    repeat (4) @(negedge clk);
    chk("busy_one_trigger", n_trig, saved + 1);
    chk("busy_slot4_data1", data1, 8'h3C);
    chk("busy_queue_drained", exp_trig.size(), 0);

    // Reset while busy drops the queued press.
    cmd_busy_i = 1'b1;
    press(2, 1'b0, 1'b0, '0);
    saved = n_trig;
    do_load();
    release_busy();
    repeat (4) @(negedge clk);
    chk("rst_drops_queue", n_trig, saved);

    // Slot 2 exhausts its retries, then recovers after two.
    fl_rty[1] = 4;
    do_load();
    fl_rty[1] = 2;
    do_load();
    fl_rty[1] = 0;

    // Reset in the middle of the first request.
    @(negedge clk);
    rst = 1'b1;
    for (int s = 0; s < N; s++) fl_left[s] = 0;
    @(negedge clk);
    exp_adr.delete();
    exp_adr.push_back(BASE);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (spi_stb_o) break;
    end
    chk("abort_stb_high", spi_stb_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_stb_low", spi_stb_o, 1'b0);
    chk("abort_slot_valid", slot_valid, '0);

    // Flash never answers: every request times out.
    fl_never = 1'b1;
    do_load();
    chk("timeout_len_min", len_min, TMO);
    chk("timeout_len_max", len_max, TMO);
    chk("timeout_requests", n_req, 4 * (MAXR + 1));
    fl_never = 1'b0;

    // Randomised loads followed by random learn/recall traffic.
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < N; s++) begin
        case ($urandom_range(0, 4))
          0: fl_word[s] = {1'($urandom), 31'($urandom)};
          1: fl_word[s] = {1'b1, 23'($urandom), 8'd10};
          2: fl_word[s] = {1'b1, 23'($urandom), 8'd20};
          default: fl_word[s] = {1'b1, 23'($urandom), 8'd30};
        endcase
        fl_rty[s] = ($urandom_range(0, 3) == 0) ? 4 : $urandom_range(0, 2);
      end
      do_load();
      run_ops(30);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
